// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   - div_state_t : FSM state encoding (IDLE, CALC, FIX, DONE)
//   - DIV_WIDTH   : default operand/result width
//   - signed_min / all_ones : width-parameterised constants. They return
//     64 bits, so the supported operand widths are 4..64; callers cast the
//     result down to their own width.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // 1 followed by w-1 zeros: the most negative two's-complement value.
   function automatic logic [63:0] signed_min(input int w);
      return 64'd1 << (w - 1);
   endfunction

   // w ones. A shift by 64 yields 0, so w=64 still wraps to all ones.
   function automatic logic [63:0] all_ones(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  [WIDTH] partial remainder from the previous step (always < divisor)
//   bit_in  [1]     next dividend bit, shifted in at the bottom
//   divisor [WIDTH] divisor magnitude
//   rem_out [WIDTH] new partial remainder
//   q_bit   [1]     quotient bit produced by this step
// The trial subtraction is built as x + ~y + 1; its carry-out is the
// not-borrow flag, i.e. 1 when the shifted remainder is >= divisor.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] sel;
   logic           carry;
   logic           unused_sel_msb;

   assign shifted = {rem_in, bit_in};
   assign {carry, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}}
                        + {{(WIDTH + 1){1'b0}}, 1'b1};

   assign q_bit = carry;
   assign sel   = carry ? diff : shifted;
   // Whichever value is kept is below the divisor, so its top bit is zero.
   assign rem_out        = sel[WIDTH-1:0];
   assign unused_sel_msb = sel[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider (shift-and-subtract).
// Build option: DIV_SIGNED_EN. When defined, signed_op selects two's-complement
// operands (magnitude conversion, sign correction in FIX, MIN/-1 overflow).
// When undefined, signed_op is ignored, all operands are unsigned, overflow
// stays 0 and FIX is a pass-through cycle, so latency does not change.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, sampled only in IDLE or DONE
//   signed_op 1 = signed operands (DIV_SIGNED_EN builds only)
//   a, b      dividend, divisor
//   busy      high in CALC and FIX
//   done      one-cycle pulse, Q/R/flags valid
//   Q, R      quotient, remainder (truncating division)
//   divZero   divisor was zero (Q = all ones, R = a)
//   overflow  signed MIN / -1 (Q = a, R = 0)
// Handshake: a request is taken on any rising edge where start=1 and the FSM
// is in IDLE or DONE (so a start held through the done cycle begins the next
// division with no gap). start during CALC/FIX is dropped, not queued.
// Results are registered on entry to DONE and hold until the next entry.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             divZero,
   output logic             overflow
);

   localparam int               CW       = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH - 1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES     = WIDTH'(all_ones(WIDTH));
   localparam logic [CW-1:0]    CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;   // dividend bits shift out the top, quotient bits in at the bottom
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;

   logic             a_neg;
   logic             b_neg;
   logic             is_ovf;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

`ifdef DIV_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

   assign a_neg  = signed_op & a[WIDTH-1];
   assign b_neg  = signed_op & b[WIDTH-1];
   assign is_ovf = signed_op & (a == MIN_VAL) & (b == ONES);
   // MIN's magnitude 2^(WIDTH-1) still fits the unsigned datapath.
   assign a_mag  = a_neg ? (~a + ONE) : a;
   assign b_mag  = b_neg ? (~b + ONE) : b;
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op;
   assign a_neg  = 1'b0;
   assign b_neg  = 1'b0;
   assign is_ovf = 1'b0;
   assign a_mag  = a;
   assign b_mag  = b;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .bit_in  (quo[WIDTH-1]),
      .divisor (dvs),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         Q        <= '0;
         R        <= '0;
         divZero  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (!start) begin
                  state <= IDLE;
               end else if (b == '0) begin
                  Q        <= ONES;
                  R        <= a;
                  divZero  <= 1'b1;
                  overflow <= 1'b0;
                  state    <= DONE;
               end else if (is_ovf) begin
                  Q        <= a;
                  R        <= '0;
                  divZero  <= 1'b0;
                  overflow <= 1'b1;
                  state    <= DONE;
               end else begin
                  quo   <= a_mag;
                  rem   <= '0;
                  dvs   <= b_mag;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  cnt   <= CNT_LAST;
                  state <= CALC;
               end
            end
            CALC: begin
               rem <= step_rem;
               quo <= {quo[WIDTH-2:0], step_q};
               cnt <= cnt - CNT_ONE;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               // Remainder follows the dividend's sign (truncating division).
               Q        <= neg_q ? (~quo + ONE) : quo;
               R        <= neg_r ? (~rem + ONE) : rem;
               divZero  <= 1'b0;
               overflow <= 1'b0;
               state    <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=32).
// Expected results come from a reference model built on native operators and
// are queued when a request is driven, then popped when done is observed.
module tb_seq_divider;

   localparam int W = 32;
`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         signed_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] Q;
   logic [W-1:0] R;
   logic         divZero;
   logic         overflow;

   int checks = 0;
   int errors = 0;
   logic [2*W+1:0] exp_q[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .Q         (Q),
      .R         (R),
      .divZero   (divZero),
      .overflow  (overflow)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Packed as {Q, R, divZero, overflow}.
   function automatic logic [2*W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] mn;
      logic         sg;
      mn = {1'b1, {(W - 1){1'b0}}};
      sg = s & SIGNED_EN;
      if (y == '0) return {{W{1'b1}}, x, 2'b10};
      if (sg && x == mn && y == {W{1'b1}}) return {x, {W{1'b0}}, 2'b01};
      if (sg) begin
         q = $signed(x) / $signed(y);
         r = $signed(x) % $signed(y);
      end else begin
         q = x / y;
         r = x % y;
      end
      return {q, r, 2'b00};
   endfunction

   // Edges from the sampling edge to the edge after which done is visible.
   function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [1:0] flags;
      logic [2*W+1:0] m;
      m = model(x, y, s);
      flags = m[1:0];
      return (flags != 2'b00) ? 1 : W + 2;
   endfunction

   // ---------------- driver tasks ----------------
   // Called between edges; the next rising edge samples start.
   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a = x;
      b = y;
      signed_op = s;
      start = 1'b1;
      exp_q.push_back(model(x, y, s));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges until done (bounded) and counts cycles where busy is wrong.
   task automatic wait_done(input int lat0, output int lat, output int busy_bad);
      lat = lat0;
      busy_bad = 0;
      while (!done && lat < 200) begin
         if (!busy) busy_bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (busy) busy_bad++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      a = 32'd5;
      b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, Q, R, divZero, overflow} !== '0) begin
         errors++;
         $display("FAIL reset outputs got busy=%b done=%b Q=%h R=%h dz=%b ov=%b exp all zero",
                  busy, done, Q, R, divZero, overflow);
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned();
      logic [W-1:0] xs [3] = '{32'd100, 32'hFFFF_FFFF, 32'd7};
      logic [W-1:0] ys [3] = '{32'd7, 32'd1, 32'd100};
      logic [W-1:0] x, y;
      logic [2*W+1:0] got, exp;
      int lat, bb;
      for (int i = 0; i < 9; i++) begin
         if (i < 3) begin
            x = xs[i];
            y = ys[i];
         end else begin
            x = $urandom;
            y = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 255);
         end
         @(negedge clk);
         launch(x, y, 1'b0);
         wait_done(1, lat, bb);
         got = {Q, R, divZero, overflow};
         exp = exp_q.pop_front();
         checks++;
         if (lat != exp_lat(x, y, 1'b0)) begin
            errors++;
            $display("FAIL unsigned[%0d] latency got %0d exp %0d", i, lat, exp_lat(x, y, 1'b0));
         end
         checks++;
         if (bb != 0) begin
            errors++;
            $display("FAIL unsigned[%0d] busy wrong in %0d cycles exp 0", i, bb);
         end
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL unsigned[%0d] %h/%h got {Q,R,dz,ov}=%h exp %h", i, x, y, got, exp);
         end
      end
   endtask

   task automatic test_signed();
      logic [W-1:0] xs [3] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
      logic [W-1:0] ys [3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [W-1:0] x, y;
      logic [2*W+1:0] got, exp;
      int lat, bb;
      for (int i = 0; i < 9; i++) begin
         if (i < 3) begin
            x = xs[i];
            y = ys[i];
         end else begin
            x = $urandom;
            y = $urandom_range(0, 1) == 1 ? $urandom : (32'd0 - $urandom_range(1, 99));
            if (y == '0) y = 32'd3;
         end
         @(negedge clk);
         launch(x, y, 1'b1);
         wait_done(1, lat, bb);
         got = {Q, R, divZero, overflow};
         exp = exp_q.pop_front();
         checks++;
         if (lat != exp_lat(x, y, 1'b1)) begin
            errors++;
            $display("FAIL signed[%0d] latency got %0d exp %0d", i, lat, exp_lat(x, y, 1'b1));
         end
         checks++;
         if (bb != 0) begin
            errors++;
            $display("FAIL signed[%0d] busy wrong in %0d cycles exp 0", i, bb);
         end
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL signed[%0d] %h/%h got {Q,R,dz,ov}=%h exp %h", i, x, y, got, exp);
         end
      end
   endtask

   task automatic test_special();
      logic [W-1:0] xs [5] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
      logic [W-1:0] ys [5] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic         ss [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [2*W+1:0] got, exp;
      int lat, bb;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         launch(xs[i], ys[i], ss[i]);
         wait_done(1, lat, bb);
         got = {Q, R, divZero, overflow};
         exp = exp_q.pop_front();
         checks++;
         if (lat != exp_lat(xs[i], ys[i], ss[i])) begin
            errors++;
            $display("FAIL special[%0d] latency got %0d exp %0d", i, lat,
                     exp_lat(xs[i], ys[i], ss[i]));
         end
         checks++;
         if (bb != 0) begin
            errors++;
            $display("FAIL special[%0d] busy wrong in %0d cycles exp 0", i, bb);
         end
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL special[%0d] got {Q,R,dz,ov}=%h exp %h", i, got, exp);
         end
      end
   endtask

   task automatic test_ignore_busy();
      logic [2*W+1:0] got, exp;
      int lat, bb;
      @(negedge clk);
      launch(32'd100, 32'd7, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      a = 32'd999;
      b = 32'd3;
      signed_op = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(5, lat, bb);
      got = {Q, R, divZero, overflow};
      exp = exp_q.pop_front();
      checks++;
      if (lat != W + 2) begin
         errors++;
         $display("FAIL ignore_busy latency got %0d exp %0d", lat, W + 2);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL ignore_busy result got %h exp %h", got, exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_busy after done got done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*W+1:0] got, exp;
      int lat, bb;
      @(negedge clk);
      launch(32'd1000, 32'd9, 1'b0);
      wait_done(1, lat, bb);
      got = {Q, R, divZero, overflow};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL back_to_back first got %h exp %h", got, exp);
      end
      // Still inside the done cycle: this request must be accepted.
      launch(32'hFFFF_FFB3, 32'd5, 1'b1);
      wait_done(1, lat, bb);
      got = {Q, R, divZero, overflow};
      exp = exp_q.pop_front();
      checks++;
      if (lat != W + 2) begin
         errors++;
         $display("FAIL back_to_back second latency got %0d exp %0d", lat, W + 2);
      end
      checks++;
      if (bb != 0) begin
         errors++;
         $display("FAIL back_to_back busy wrong in %0d cycles exp 0", bb);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL back_to_back second got %h exp %h", got, exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [2*W+1:0] got, exp;
      logic [2*W+1:0] dropped;
      int lat, bb, seen;
      @(negedge clk);
      launch(32'd12345, 32'd67, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done, Q, R, divZero, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs got busy=%b done=%b Q=%h R=%h dz=%b ov=%b exp all zero",
                  busy, done, Q, R, divZero, overflow);
      end
      rst_n = 1'b1;
      dropped = exp_q.pop_back();
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid aborted division pulsed done %0d times exp 0 (dropped %h)",
                  seen, dropped);
      end
      @(negedge clk);
      launch(32'd12345, 32'd67, 1'b0);
      wait_done(1, lat, bb);
      got = {Q, R, divZero, overflow};
      exp = exp_q.pop_front();
      checks++;
      if (lat != W + 2) begin
         errors++;
         $display("FAIL reset_mid restart latency got %0d exp %0d", lat, W + 2);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_mid restart got %h exp %h", got, exp);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      signed_op = 1'b0;
      a = '0;
      b = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard leftover entries got %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
